// File: rtl/freqmeter_result_scheduler.sv
// Round-robin arbiter that moves per-channel frequency results into a result RAM,
// one write per grant, and flags when every enabled channel has been written.
module freqmeter_result_scheduler #(
    parameter int INPUTS_COUNT = 24,
    parameter int CNT_W        = 30,
    parameter int ADDR_W       = 5
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [INPUTS_COUNT-1:0]         enable_mask_i,
    input  logic [INPUTS_COUNT-1:0]         req_i,
    input  logic [INPUTS_COUNT*CNT_W-1:0]   ch_data_i,
    output logic [INPUTS_COUNT-1:0]         gnt_o,
    output logic                            wr_en_o,
    output logic [ADDR_W-1:0]               wr_addr_o,
    output logic [CNT_W-1:0]                wr_data_o,
    output logic                            busy_o,
    output logic                            cycle_done_o
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] WRITE = 1'b1;
    localparam logic [INPUTS_COUNT-1:0] ONE = {{(INPUTS_COUNT-1){1'b0}}, 1'b1};

    logic [0:0]              state;
    logic [ADDR_W-1:0]       rr_ptr;
    logic [ADDR_W-1:0]       idx;
    logic [INPUTS_COUNT-1:0] serviced;
    logic [INPUTS_COUNT-1:0] eff;
    logic [INPUTS_COUNT-1:0] serviced_next;
    logic [ADDR_W:0]         pick;
    logic                    found;
    logic [ADDR_W-1:0]       win;
    logic                    round_complete;

    // Returns {found, index}; scanning offsets high-to-low lets the closest one to ptr win.
    function automatic logic [ADDR_W:0] pick_winner(input logic [INPUTS_COUNT-1:0] req,
                                                    input logic [ADDR_W-1:0] ptr);
        logic [ADDR_W:0] res;
        int c;
        res = '0;
        for (int off = INPUTS_COUNT - 1; off >= 0; off--) begin
            c = int'(ptr) + off;
            if (c >= INPUTS_COUNT) c = c - INPUTS_COUNT;
            if (req[c]) res = {1'b1, ADDR_W'(c)};
        end
        return res;
    endfunction

    always_comb begin
        eff            = req_i & enable_mask_i;
        pick           = pick_winner(eff, rr_ptr);
        found          = pick[ADDR_W];
        win            = pick[ADDR_W-1:0];
        serviced_next  = serviced | (ONE << idx);
        round_complete = (enable_mask_i != '0) && (&(serviced_next | ~enable_mask_i));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            idx          <= '0;
            serviced     <= '0;
            gnt_o        <= '0;
            wr_en_o      <= 1'b0;
            wr_addr_o    <= '0;
            wr_data_o    <= '0;
            busy_o       <= 1'b0;
            cycle_done_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cycle_done_o <= 1'b0;
                    if (found) begin
                        state     <= WRITE;
                        idx       <= win;
                        gnt_o     <= ONE << win;
                        wr_en_o   <= 1'b1;
                        wr_addr_o <= win;
                        wr_data_o <= ch_data_i[int'(win)*CNT_W +: CNT_W];
                        busy_o    <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    gnt_o   <= '0;
                    wr_en_o <= 1'b0;
                    busy_o  <= 1'b0;
                    rr_ptr  <= (idx == ADDR_W'(INPUTS_COUNT - 1)) ? '0 : idx + 1'b1;
                    // Completion ignores channels whose enable has since dropped.
                    if (round_complete) begin
                        cycle_done_o <= 1'b1;
                        serviced     <= '0;
                    end else begin
                        serviced     <= serviced_next;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freqmeter_result_scheduler.sv
// Bench for freqmeter_result_scheduler: directed vector table, hand-written
// round-robin / wrap sequences, and randomized traffic against a reference model.
module tb_freqmeter_result_scheduler;

    localparam int N  = 24;
    localparam int W  = 30;
    localparam int AW = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    mask;
    logic [N-1:0]    req;
    logic [N*W-1:0]  ch_data;
    logic [N-1:0]    gnt;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [W-1:0]    wr_data;
    logic            busy;
    logic            done;

    int vectors = 0;
    int miscompares = 0;

    freqmeter_result_scheduler #(.INPUTS_COUNT(N), .CNT_W(W), .ADDR_W(AW)) dut (
        .clk_i(clk), .rst_i(rst), .enable_mask_i(mask), .req_i(req), .ch_data_i(ch_data),
        .gnt_o(gnt), .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
        .busy_o(busy), .cycle_done_o(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic [N-1:0] mask;
        logic [N-1:0] req;
        logic [W-1:0] base;
        logic         en;
        logic [AW-1:0] addr;
        logic [W-1:0] data;
        logic [N-1:0] gnt;
        logic         busy;
        logic         done;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_data(input logic [W-1:0] base);
        for (int k = 0; k < N; k++) ch_data[k*W +: W] = base + W'(k);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; req = '0; mask = '1; set_data('0);
        step();
        rst = 1'b0;
    endtask

    // Reference model state
    logic          m_busy, m_en, m_done;
    int            m_idx, m_rr;
    logic [N-1:0]  m_serv, m_gnt;
    logic [AW-1:0] m_addr;
    logic [W-1:0]  m_data;

    task automatic model_reset;
        m_busy = 0; m_en = 0; m_done = 0; m_idx = 0; m_rr = 0;
        m_serv = '0; m_gnt = '0; m_addr = '0; m_data = '0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step;
        int  c;
        bit  all_done;
        if (rst) begin
            model_reset();
        end else if (m_busy) begin
            m_busy = 0; m_en = 0; m_gnt = '0;
            m_rr = (m_idx + 1) % N;
            m_serv[m_idx] = 1'b1;
            all_done = (mask != '0);
            for (int k = 0; k < N; k++) if (mask[k] && !m_serv[k]) all_done = 0;
            m_done = all_done;
            if (all_done) m_serv = '0;
        end else begin
            m_done = 0;
            for (int off = 0; off < N; off++) begin
                c = (m_rr + off) % N;
                if (req[c] && mask[c]) begin
                    m_busy = 1; m_en = 1; m_idx = c;
                    m_gnt = '0; m_gnt[c] = 1'b1;
                    m_addr = AW'(c);
                    m_data = ch_data[c*W +: W];
                    break;
                end
            end
        end
    endtask

    initial begin
        logic [N-1:0] g_last, cur, prev_gnt;
        int           exp_seq[6];
        int           k;
        logic         prev_en;

        // rst  mask         req          base          en addr  data          gnt          busy done
        tbl[0]  = '{1'b1, 24'hFFFFFF, 24'h000000, 30'h0,       1'b0, 5'd0,  30'h0,       24'h000000, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 24'hFFFFFF, 24'h000020, 30'h1234562, 1'b1, 5'd5,  30'h1234567, 24'h000020, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 24'hFFFFFF, 24'h000020, 30'h5,       1'b0, 5'd0,  30'h0,       24'h000000, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 24'hFFFFFF, 24'h000000, 30'h0,       1'b0, 5'd0,  30'h0,       24'h000000, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 24'h000003, 24'hFFFFFF, 30'h100,     1'b1, 5'd0,  30'h100,     24'h000001, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 24'h000003, 24'hFFFFFE, 30'h200,     1'b0, 5'd0,  30'h0,       24'h000000, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 24'h000003, 24'hFFFFFE, 30'h300,     1'b1, 5'd1,  30'h301,     24'h000002, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 24'h000003, 24'hFFFFFC, 30'h400,     1'b0, 5'd0,  30'h0,       24'h000000, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 24'h000003, 24'hFFFFFC, 30'h0,       1'b0, 5'd0,  30'h0,       24'h000000, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 24'h000003, 24'h000003, 30'h10,      1'b1, 5'd0,  30'h10,      24'h000001, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 24'h000003, 24'h000002, 30'h20,      1'b0, 5'd0,  30'h0,       24'h000000, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 24'h000000, 24'h000002, 30'h0,       1'b0, 5'd0,  30'h0,       24'h000000, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 24'hFFFFFF, 24'h800000, 30'h0,       1'b1, 5'd23, 30'h17,      24'h800000, 1'b1, 1'b0};
        tbl[13] = '{1'b1, 24'hFFFFFF, 24'h800000, 30'h0,       1'b0, 5'd0,  30'h0,       24'h000000, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 24'hFFFFFF, 24'h800001, 30'h50,      1'b1, 5'd0,  30'h50,      24'h000001, 1'b1, 1'b0};
        tbl[15] = '{1'b0, 24'hFFFFFF, 24'h800000, 30'h0,       1'b0, 5'd0,  30'h0,       24'h000000, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 24'hFFFFFF, 24'h800000, 30'h60,      1'b1, 5'd23, 30'h77,      24'h800000, 1'b1, 1'b0};
        tbl[17] = '{1'b0, 24'hFFFFFF, 24'h000000, 30'h0,       1'b0, 5'd0,  30'h0,       24'h000000, 1'b0, 1'b0};

        rst = 1'b1; mask = '0; req = '0; ch_data = '0;

        for (int i = 0; i < 18; i++) begin
            rst = tbl[i].rst; mask = tbl[i].mask; req = tbl[i].req; set_data(tbl[i].base);
            step();
            chk($sformatf("tbl%0d.wr_en", i), 32'(wr_en), 32'(tbl[i].en));
            chk($sformatf("tbl%0d.gnt", i),   32'(gnt),   32'(tbl[i].gnt));
            chk($sformatf("tbl%0d.busy", i),  32'(busy),  32'(tbl[i].busy));
            chk($sformatf("tbl%0d.done", i),  32'(done),  32'(tbl[i].done));
            if (tbl[i].en || tbl[i].rst) begin
                chk($sformatf("tbl%0d.addr", i), 32'(wr_addr), 32'(tbl[i].addr));
                chk($sformatf("tbl%0d.data", i), 32'(wr_data), 32'(tbl[i].data));
            end
        end

        // Round robin over ch0..2; each requester drops for one cycle after its grant.
        do_reset();
        exp_seq = '{0, 1, 2, 0, 1, 2};
        k = 0; g_last = '0; prev_en = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cur = gnt;
            req = N'(7) & ~g_last;
            g_last = cur;
            set_data(W'($urandom));
            step();
            if (wr_en) begin
                if (k < 6) chk($sformatf("rr.grant%0d", k), 32'(wr_addr), 32'(exp_seq[k]));
                k++;
            end
            if (prev_en) chk("rr.idle_gap", 32'(wr_en), 32'(0));
            prev_en = wr_en;
        end
        chk("rr.count", 32'(k), 32'(6));

        // Wrap: grant ch22 so the pointer moves to 23, then ch23 must beat ch0.
        do_reset();
        req = N'(1) << 22; step();
        chk("wrap.g22", 32'(gnt), 32'(N'(1) << 22));
        step();
        req = (N'(1) << 23) | N'(1); step();
        chk("wrap.g23", 32'(wr_addr), 32'(23));
        req = N'(1); step();
        chk("wrap.gap", 32'(wr_en), 32'(0));
        step();
        chk("wrap.g0", 32'(gnt), 32'(1));
        req = '0; step();

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        prev_gnt = '0;
        req = '0;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 3))
                    0: mask = '1;
                    1: mask = '0;
                    2: mask = N'($urandom_range(1, 255));
                    default: mask = N'($urandom);
                endcase
            end
            req = req & ~prev_gnt;
            for (int c = 0; c < N; c++)
                if (!req[c] && !prev_gnt[c] && $urandom_range(0, 3) == 0) req[c] = 1'b1;
            for (int c = 0; c < N; c++) ch_data[c*W +: W] = W'($urandom);
            prev_gnt = gnt;
            model_step();
            step();
            chk("rnd.wr_en", 32'(wr_en),   32'(m_en));
            chk("rnd.gnt",   32'(gnt),     32'(m_gnt));
            chk("rnd.busy",  32'(busy),    32'(m_busy));
            chk("rnd.done",  32'(done),    32'(m_done));
            chk("rnd.addr",  32'(wr_addr), 32'(m_addr));
            chk("rnd.data",  32'(wr_data), 32'(m_data));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
